// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential right shifter: default geometry,
// FSM state encoding and the fill-select codes used by the shift stages.
// No ports (package).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  // Two-bit state register; code 2'b10 and 2'b11 are unused and recover to idle.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  // Fill-select codes for the vacated high-order bits of a stage.
  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_SIGN = 1'b1;

endpackage

// File: rtl/right_shift_stage.sv
// -----------------------------------------------------------------------------
// right_shift_stage
// One combinational barrel stage: shifts the input right by a fixed DIST bits
// and fills the vacated top bits with zero or with the input's MSB.
// Ports:
//   i_data      in  WIDTH  value to shift
//   i_fill_sel  in  1      FILL_ZERO or FILL_SIGN
//   o_data      out WIDTH  shifted value
// DIST must be smaller than WIDTH.
// -----------------------------------------------------------------------------
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_fill_sel,
  output logic [WIDTH-1:0] o_data
);

  logic w_fill;

  assign w_fill = (i_fill_sel == FILL_SIGN) ? i_data[WIDTH-1] : 1'b0;
  assign o_data = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};

endmodule

// File: rtl/seq_right_shifter.sv
// -----------------------------------------------------------------------------
// seq_right_shifter
// Multi-cycle logical/arithmetic right shifter. One barrel stage is resolved
// per clock, largest distance first, so every operation takes exactly SHAMT_W
// cycles regardless of the shift amount.
// Ports:
//   clock           in  1        rising-edge clock
//   reset_n         in  1        asynchronous active-low reset
//   ctrl_start      in  1        start request, honoured only when idle
//   ctrl_arith      in  1        1 = sign fill, 0 = zero fill (captured at start)
//   ctrl_flush      in  1        abandon the in-flight operation
//   data_operand    in  WIDTH    value to shift (captured at start)
//   shamt           in  SHAMT_W  shift amount (captured at start)
//   data_result     out WIDTH    last completed result, held between completions
//   data_resultRDY  out 1        one-cycle pulse when data_result updates
//   busy            out 1        operation in flight
// -----------------------------------------------------------------------------
module seq_right_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_start,
  input  logic               ctrl_arith,
  input  logic               ctrl_flush,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int             K_W    = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_sh;
  logic               r_ar;
  logic [K_W-1:0]     r_k;
  logic [WIDTH-1:0]   r_result;
  logic               r_rdy;
  logic               r_busy;

  logic             w_fill_sel;
  logic [WIDTH-1:0] w_stage [SHAMT_W];
  logic [WIDTH-1:0] w_stage_sel;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_fill_sel = r_ar ? FILL_SIGN : FILL_ZERO;

  // Every stage sees the accumulator; only the one selected by r_k is used.
  // The fill bit is taken from the current accumulator MSB, which still
  // equals the original sign because earlier stages filled with it.
  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      right_shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << gi)
      ) u_stage (
        .i_data     (r_acc),
        .i_fill_sel (w_fill_sel),
        .o_data     (w_stage[gi])
      );
    end
  endgenerate

  always_comb begin
    w_stage_sel = r_acc;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (r_k == K_W'(i)) begin
        w_stage_sel = w_stage[i];
      end
    end
  end

  assign w_acc_next = r_sh[r_k] ? w_stage_sel : r_acc;
  assign w_last     = (r_k == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_sh     <= '0;
      r_ar     <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Flush outranks start, so a simultaneous request is dropped.
          if (ctrl_start && !ctrl_flush) begin
            r_acc   <= data_operand;
            r_sh    <= shamt;
            r_ar    <= ctrl_arith;
            r_k     <= K_LAST;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ctrl_flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_next;
            if (w_last) begin
              // Publish the stage-0 output directly rather than the old acc.
              r_result <= w_acc_next;
              r_rdy    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_k <= r_k - K_W'(1);
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_seq_right_shifter.sv
module tb_seq_right_shifter;

  logic        clock;
  logic        reset_n;
  logic        ctrl_start;
  logic        ctrl_arith;
  logic        ctrl_flush;
  logic [31:0] data_operand;
  logic [4:0]  shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .ctrl_arith     (ctrl_arith),
    .ctrl_flush     (ctrl_flush),
    .data_operand   (data_operand),
    .shamt          (shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every RDY pulse must match the oldest queued expectation,
  // both in value and in the cycle it appears.
  always @(negedge clock) begin
    if (reset_n && data_resultRDY) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: got pulse at cycle %0d with result 0x%08h, required none",
                 cyc_cnt, data_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, data_result, e.val);
        check({e.name, "_latency"}, 32'(cyc_cnt), 32'(e.due));
      end
    end
  end

  // Start an operation, confirm busy for the five shift cycles, and leave
  // the bench positioned just after the completion edge.
  task automatic run_op(input string name, input logic [31:0] opnd, input logic [4:0] amt,
                        input logic ar, input logic [31:0] req);
    ctrl_start   = 1'b1;
    data_operand = opnd;
    shamt        = amt;
    ctrl_arith   = ar;
    sb_q.push_back('{name: name, val: req, due: cyc_cnt + 6});
    step();
    ctrl_start   = 1'b0;
    data_operand = $urandom;
    shamt        = 5'($urandom);
    ctrl_arith   = ~ar;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 4) check({name, "_busy"}, {31'b0, busy}, 32'd1);
      step();
    end
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // Start an operation that is expected never to complete.
  task automatic start_silent(input logic [31:0] opnd, input logic [4:0] amt);
    ctrl_start   = 1'b1;
    data_operand = opnd;
    shamt        = amt;
    ctrl_arith   = 1'b0;
    step();
    ctrl_start   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    ctrl_start   = 1'b0;
    ctrl_arith   = 1'b0;
    ctrl_flush   = 1'b0;
    data_operand = '0;
    shamt        = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    check("reset_result", data_result, 32'h0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);

    // Main function, including back-to-back starts in the RDY cycle.
    run_op("srl_4",        32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F);
    run_op("sra_4",        32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F);
    run_op("sra_31",       32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("srl_31",       32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("shamt_0",      32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678);
    run_op("srl_16",       32'h1234_5678, 5'd16, 1'b0, 32'h0000_1234);
    run_op("srl_31_pos",   32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000);
    run_op("sra_pos",      32'h7FFF_0000, 5'd4,  1'b1, 32'h07FF_F000);
    run_op("sra_mixed_21", 32'hC000_0001, 5'd21, 1'b1, 32'hFFFF_FE00);
    step();

    // A start raised while shifting must be ignored.
    sb_q.push_back('{name: "ignored_start", val: 32'h00FF_FF00, due: cyc_cnt + 6});
    ctrl_start   = 1'b1;
    data_operand = 32'hFFFF_0000;
    shamt        = 5'd8;
    ctrl_arith   = 1'b0;
    step();
    ctrl_start = 1'b0;
    step();
    ctrl_start   = 1'b1;
    data_operand = 32'h0000_0001;
    shamt        = 5'd1;
    step();
    ctrl_start = 1'b0;
    repeat (3) step();
    check("ignored_start_idle", {31'b0, busy}, 32'd0);
    repeat (3) step();

    // Flush mid-operation: no pulse, result held, idle next cycle.
    start_silent(32'h1234_5678, 5'd4);
    step();
    step();
    ctrl_flush = 1'b1;
    step();
    ctrl_flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hold", data_result, 32'h00FF_FF00);
    repeat (6) step();
    check("flush_hold_later", data_result, 32'h00FF_FF00);
    run_op("after_flush", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F);
    step();

    // Flush on the completion edge wins.
    start_silent(32'hFFFF_FFFF, 5'd1);
    repeat (4) step();
    ctrl_flush = 1'b1;
    step();
    ctrl_flush = 1'b0;
    check("flush_last_busy", {31'b0, busy}, 32'd0);
    repeat (3) step();
    check("flush_last_hold", data_result, 32'h0000_000F);

    // Flush with start while idle: nothing starts.
    ctrl_flush   = 1'b1;
    ctrl_start   = 1'b1;
    data_operand = 32'hAAAA_AAAA;
    shamt        = 5'd1;
    step();
    ctrl_flush = 1'b0;
    ctrl_start = 1'b0;
    check("flush_start_idle", {31'b0, busy}, 32'd0);
    repeat (6) step();
    check("flush_start_hold", data_result, 32'h0000_000F);

    // Asynchronous reset mid-shift, two cycles after the start edge.
    start_silent(32'hFFFF_FFFF, 5'd1);
    step();
    step();
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("async_reset_result", data_result, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    repeat (6) step();
    check("post_reset_result", data_result, 32'h0);
    run_op("post_reset_op", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);

    repeat (3) step();
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
